// File: rtl/clock_div_prog_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Ratios are carried at a fixed maximum width and sized down per instance.
package clock_div_prog_pkg;

   localparam int CNT_W_MAX = 16;

   typedef logic [CNT_W_MAX-1:0] ratio_t;

   localparam ratio_t RATIO_MIN = ratio_t'(1);

   function automatic ratio_t clamp_ratio(input ratio_t r);
      return (r == '0) ? RATIO_MIN : r;
   endfunction

   // ceil(r/2) written so it cannot overflow at the top of the range
   function automatic ratio_t high_len(input ratio_t r);
      return (r >> 1) + {{(CNT_W_MAX-1){1'b0}}, r[0]};
   endfunction

endpackage

// File: rtl/clock_div_ch.sv
// One divider channel: period counter, pending ratio, enable/align
// handling and registered clock / enable decode.
module clock_div_ch
   import clock_div_prog_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int DEF_DIV = 2
) (
   input  logic             sys_clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] i_ratio,
   input  logic             i_load,
   input  logic             i_enable,
   input  logic             i_align,
   output logic             o_clk,
   output logic             o_en,
   output logic [CNT_W-1:0] o_ratio,
   output logic             o_pending
);

   localparam logic [CNT_W-1:0] DEF_R = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_ratio;
   logic [CNT_W-1:0] r_pend_ratio;
   logic             r_pending;
   logic             r_clk;
   logic             r_en;

   logic [CNT_W-1:0] w_load_val;
   logic [CNT_W-1:0] w_apply_r;
   logic [CNT_W-1:0] w_cnt_n;
   logic [CNT_W-1:0] w_ratio_n;
   logic [CNT_W-1:0] w_pend_ratio_n;
   logic             w_pending_n;
   logic             w_wrap;
   logic             w_run;
   logic             w_clk_n;
   logic             w_en_n;

   assign w_load_val = CNT_W'(clamp_ratio(ratio_t'(i_ratio)));
   assign w_apply_r  = r_pending ? r_pend_ratio : r_ratio;
   assign w_wrap     = (r_cnt == r_ratio - ONE);

   always_comb begin
      w_cnt_n        = r_cnt;
      w_ratio_n      = r_ratio;
      w_pending_n    = r_pending;
      w_run          = 1'b1;
      w_pend_ratio_n = i_load ? w_load_val : r_pend_ratio;
      priority case (1'b1)
         !i_enable: begin
            w_ratio_n   = w_apply_r;
            w_pending_n = 1'b0;
            w_cnt_n     = w_apply_r - ONE;
            w_run       = 1'b0;
         end
         i_align, w_wrap: begin
            w_ratio_n   = w_apply_r;
            w_pending_n = 1'b0;
            w_cnt_n     = '0;
         end
         default: w_cnt_n = r_cnt + ONE;
      endcase
      // a capture in the same cycle as an apply keeps the flag set
      if (i_load) w_pending_n = 1'b1;
      w_clk_n = w_run &&
         (ratio_t'(w_cnt_n) < high_len(ratio_t'(w_ratio_n)));
      w_en_n  = w_run && (w_cnt_n == w_ratio_n - ONE);
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_cnt        <= DEF_R - ONE;
         r_ratio      <= DEF_R;
         r_pend_ratio <= DEF_R;
         r_pending    <= 1'b0;
         r_clk        <= 1'b0;
         r_en         <= 1'b0;
      end else begin
         r_cnt        <= w_cnt_n;
         r_ratio      <= w_ratio_n;
         r_pend_ratio <= w_pend_ratio_n;
         r_pending    <= w_pending_n;
         r_clk        <= w_clk_n;
         r_en         <= w_en_n;
      end
   end

   assign o_clk     = r_clk;
   assign o_en      = r_en;
   assign o_ratio   = r_ratio;
   assign o_pending = r_pending;

endmodule

// File: rtl/clock_div_prog.sv
// Multi-channel programmable clock divider / clock-enable generator.
// Each channel is independent apart from the shared align pulse.
module clock_div_prog
   import clock_div_prog_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 8,
   parameter int DEF_DIV = 2
) (
   input  logic                    sys_clk,
   input  logic                    rst,
   input  logic [NUM_CH*CNT_W-1:0] div_ratio,
   input  logic [NUM_CH-1:0]       div_load,
   input  logic [NUM_CH-1:0]       ch_enable,
   input  logic                    align,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       clk_en,
   output logic [NUM_CH*CNT_W-1:0] ratio_active,
   output logic [NUM_CH-1:0]       pending
);

   logic w_align;

   assign w_align = align;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clock_div_ch #(
         .CNT_W   (CNT_W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .sys_clk   (sys_clk),
         .rst       (rst),
         .i_ratio   (div_ratio[g*CNT_W +: CNT_W]),
         .i_load    (div_load[g]),
         .i_enable  (ch_enable[g]),
         .i_align   (w_align),
         .o_clk     (clk_out[g]),
         .o_en      (clk_en[g]),
         .o_ratio   (ratio_active[g*CNT_W +: CNT_W]),
         .o_pending (pending[g])
      );
   end

endmodule
